aes_enc_feeder: RTL and testbench
=================================

// Module: aes_enc_feeder
// PURPOSE
//  Upstream issue stage for the AES-128 encryption core. Accepts {plaintext,key} blocks on a
//  valid/ready interface, buffers them in a DEPTH-entry FIFO and launches one block at a time
//  into the core with a single-cycle core_data_v_o pulse. It never re-launches until the core
//  has returned its result and the core round counter is back to 0.
// PARAMETERS
//  DEPTH     4   FIFO entries; power of 2, >= 2
//  AW        2   log2(DEPTH)
//  WDOG_MAX  15  RUN-state cycle limit before timeout; used only with AES_FEEDER_WDOG_EN
// PORTS
//  clk            in   1    clock, all flops on rising edge
//  nreset         in   1    asynchronous active-low reset
//  in_v_i         in   1    upstream block valid
//  in_rdy_o       out  1    FIFO can accept; equals !full
//  in_data_i      in   128  plaintext block
//  in_key_i       in   128  cipher key for this block
//  core_data_v_o  out  1    launch pulse to core data_v_i
//  core_data_o    out  128  plaintext to core data_i
//  core_key_o     out  128  key to core key_i
//  core_res_v_i   in   1    core res_v_o; result-valid pulse
//  busy_o         out  1    (state != IDLE) | (level != 0)
//  level_o        out  AW+1 FIFO occupancy, 0..DEPTH
//  err_o          out  1    sticky watchdog error; constant 0 without AES_FEEDER_WDOG_EN
// BEHAVIOUR
//  Reset (async): state=IDLE, rd/wr ptr=0, level=0, core_data_v_o=0, core_data_o=0,
//   core_key_o=0, err_o=0, wdog count=0. FIFO storage is not reset.
//  FIFO: 256-bit entries {data,key}. Push when in_v_i & in_rdy_o. in_rdy_o = (level != DEPTH),
//   with no same-cycle pop bypass: a full FIFO refuses even when a pop happens this cycle.
//   Push and pop in the same cycle leave level unchanged. Pointers wrap modulo DEPTH.
//  FSM, all transitions registered:
//   IDLE   : if level != 0, pop the head into core_data_o/core_key_o and go to LAUNCH.
//   LAUNCH : core_data_v_o = 1 for exactly this cycle, then go to RUN.
//   RUN    : wait. On core_res_v_i go to IDLE.
//  core_data_v_o is registered and high only in LAUNCH.
//  core_data_o/core_key_o hold their value until the next pop.
//  Latency: push at edge E gives IDLE pop at edge E+1 and core_data_v_o high in cycle E+2.
//  Throughput: launch in cycle L gives core_res_v_i in cycle L+11. RUN goes to IDLE at edge
//   L+11, with pop at L+12 and the next launch in cycle L+13. Launching during the res_v
//   cycle is forbidden because it would corrupt the core counter.
//  core_res_v_i in IDLE or LAUNCH: ignored, no state change.
//  Upstream push while RUN: accepted if not full, and queued.
//  Reset mid-operation: any in-flight and queued blocks are dropped. The core is reset by the
//   same nreset.
// CONFIGURATION
//  AES_FEEDER_WDOG_EN defined:
//   - A counter clears on RUN entry and increments each RUN cycle.
//   - If it reaches WDOG_MAX with no core_res_v_i: err_o <= 1 (sticky until reset) and
//     state <= IDLE, so the next queued block proceeds.
//   - core_res_v_i in the same cycle as the limit wins: normal exit, no error.
//  AES_FEEDER_WDOG_EN undefined: no counter, err_o tied 0, RUN waits indefinitely.
// TESTING
//  1. Reset, then push data=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f
//     with the core attached -> one core_data_v_o pulse 2 cycles after the push; res_o =
//     69c4e0d86a7b0430d8cdb78070b4c55a with res_v 11 cycles later.
//  2. Push 4 blocks back-to-back into an idle block with DEPTH=4 -> in_rdy_o stays 1
//     throughout; launches are spaced exactly 13 cycles apart; results come out in push order.
//  3. Hold in_v_i=1 until in_rdy_o=0 (core busy) -> level_o=4 and in_rdy_o=0. Continue holding
//     in_v_i across a pop cycle -> no push in the pop cycle; level 4->3, then the next push
//     returns it to 4.
//  4. Inject core_res_v_i pulses in IDLE and in LAUNCH -> no state change, no extra launch;
//     core_data_v_o count equals the number of pushes.
//  5. Assert nreset mid-RUN with 2 blocks queued -> all outputs immediately at reset values,
//     level_o=0, no launch until a new push.
//  6. With AES_FEEDER_WDOG_EN, launch with core_res_v_i held 0 -> err_o=1 after WDOG_MAX RUN
//     cycles, and the queued block launches 2 cycles later. Without the macro, err_o stays 0
//     and the FSM stays in RUN.

Source files
------------

// File: rtl/aes_enc_feeder.sv
// aes_enc_feeder: FIFO-buffered issue stage launching one {plaintext,key} block at a time into
// the AES-128 core. Optional RUN-state watchdog when AES_FEEDER_WDOG_EN is defined.
module aes_enc_feeder #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int WDOG_MAX = 15
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_v_i,
  output logic         in_rdy_o,
  input  logic [127:0] in_data_i,
  input  logic [127:0] in_key_i,
  output logic         core_data_v_o,
  output logic [127:0] core_data_o,
  output logic [127:0] core_key_o,
  input  logic         core_res_v_i,
  output logic         busy_o,
  output logic [AW:0]  level_o,
  output logic         err_o
);

  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_LAUNCH = 2'd1;
  localparam logic [1:0]    S_RUN    = 2'd2;
  localparam logic [AW:0]   LVL_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [255:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [1:0]    r_state;
  logic          r_rdy;
  logic          r_busy;
  logic          r_core_v;
  logic [127:0]  r_core_data;
  logic [127:0]  r_core_key;

  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_state_nxt;
  logic [AW:0]   w_level_nxt;
  logic [255:0]  w_head;

`ifdef AES_FEEDER_WDOG_EN
  localparam int            WW        = $clog2(WDOG_MAX + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_MAX - 1);
  localparam logic [WW-1:0] WDOG_ZERO = {WW{1'b0}};
  localparam logic [WW-1:0] WDOG_ONE  = WW'(1);
  logic [WW-1:0] r_wdog;
  logic          r_err;
  logic [WW-1:0] w_wdog_nxt;
  logic          w_err_nxt;
`endif

  // in_rdy_o is registered from next level, so it never sees a same-cycle pop
  assign w_push = in_v_i & r_rdy;
  assign w_head = r_mem[r_rd_ptr];

  // Next-state logic: pop only from IDLE, exit RUN on result (or watchdog expiry)
  always_comb begin
    w_pop       = 1'b0;
    w_state_nxt = r_state;
`ifdef AES_FEEDER_WDOG_EN
    w_wdog_nxt  = r_wdog;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_level != LVL_ZERO) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_RUN;
`ifdef AES_FEEDER_WDOG_EN
        w_wdog_nxt  = WDOG_ZERO;
`endif
      end
      S_RUN: begin
        if (core_res_v_i) begin
          w_state_nxt = S_IDLE;
        end else begin
`ifdef AES_FEEDER_WDOG_EN
          if (r_wdog == WDOG_LAST) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end else begin
            w_wdog_nxt  = r_wdog + WDOG_ONE;
          end
`else
          w_state_nxt = S_RUN;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Occupancy update; simultaneous push and pop cancel out
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_data_i, in_key_i};
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= PTR_ZERO;
      r_rd_ptr    <= PTR_ZERO;
      r_level     <= LVL_ZERO;
      r_rdy       <= 1'b1;
      r_busy      <= 1'b0;
      r_core_v    <= 1'b0;
      r_core_data <= 128'h0;
      r_core_key  <= 128'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_rdy    <= (w_level_nxt != LVL_FULL);
      r_busy   <= (w_state_nxt != S_IDLE) | (w_level_nxt != LVL_ZERO);
      r_core_v <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_core_data <= w_head[255:128];
        r_core_key  <= w_head[127:0];
      end
    end
  end

`ifdef AES_FEEDER_WDOG_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wdog <= WDOG_ZERO;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= w_wdog_nxt;
      r_err  <= w_err_nxt;
    end
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign in_rdy_o      = r_rdy;
  assign busy_o        = r_busy;
  assign level_o       = r_level;
  assign core_data_v_o = r_core_v;
  assign core_data_o   = r_core_data;
  assign core_key_o    = r_core_key;

endmodule

// File: tb/tb_aes_enc_feeder.sv
// tb_aes_enc_feeder: randomized and directed bench for aes_enc_feeder against a
// transaction-level model of block queueing and launch timing (core modelled as fixed latency).
module tb_aes_enc_feeder;
  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int WDOG_MAX = 15;
  localparam int CORE_LAT = 11;

  logic         clk = 1'b0;
  logic         nreset = 1'b1;
  logic         in_v_i = 1'b0;
  logic         in_rdy_o;
  logic [127:0] in_data_i = 128'h0;
  logic [127:0] in_key_i = 128'h0;
  logic         core_data_v_o;
  logic [127:0] core_data_o;
  logic [127:0] core_key_o;
  logic         core_res_v_i = 1'b0;
  logic         busy_o;
  logic [AW:0]  level_o;
  logic         err_o;

  aes_enc_feeder #(.DEPTH(DEPTH), .AW(AW), .WDOG_MAX(WDOG_MAX)) dut (
    .clk(clk), .nreset(nreset),
    .in_v_i(in_v_i), .in_rdy_o(in_rdy_o), .in_data_i(in_data_i), .in_key_i(in_key_i),
    .core_data_v_o(core_data_v_o), .core_data_o(core_data_o), .core_key_o(core_key_o),
    .core_res_v_i(core_res_v_i), .busy_o(busy_o), .level_o(level_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: queued blocks with their push cycle; one block in flight in the core at a time.
  // A block launches at the earliest cycle that is >= push+2 and >= previous exit+2.
  logic [255:0] m_q[$];
  int           m_qt[$];
  logic [255:0] m_head = 256'h0;
  bit           m_inflight = 1'b0;
  int           m_launch_cyc = 0;
  int           m_free = 0;
  int           m_res_due = -1;
  bit           m_err = 1'b0;
  bit           m_launch;
  bit           suppress_core = 1'b0;
  int           cnt_push = 0;
  int           cnt_launch = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply the effect of the inputs held during the current cycle
  task automatic commit();
    if (in_v_i && m_q.size() != DEPTH) begin
      m_q.push_back({in_data_i, in_key_i});
      m_qt.push_back(cyc);
      cnt_push++;
    end
    if (m_inflight && cyc > m_launch_cyc) begin
      if (core_res_v_i) begin
        m_inflight = 1'b0;
        m_free = cyc + 2;
      end
`ifdef AES_FEEDER_WDOG_EN
      else if (cyc == m_launch_cyc + WDOG_MAX) begin
        m_inflight = 1'b0;
        m_free = cyc + 2;
        m_err = 1'b1;
      end
`endif
    end
  endtask

  // Compute expectations for the current cycle and compare every output
  task automatic eval();
    m_launch = 1'b0;
    if (!m_inflight && m_q.size() != 0 && cyc >= m_qt[0] + 2 && cyc >= m_free) begin
      m_head = m_q.pop_front();
      void'(m_qt.pop_front());
      m_launch = 1'b1;
      m_inflight = 1'b1;
      m_launch_cyc = cyc;
      m_res_due = suppress_core ? -1 : cyc + CORE_LAT;
    end
    if (core_data_v_o === 1'b1) cnt_launch++;
    chk("launch", core_data_v_o, m_launch);
    chk("core_data", core_data_o, m_head[255:128]);
    chk("core_key", core_key_o, m_head[127:0]);
    chk("level", level_o, m_q.size());
    chk("in_rdy", in_rdy_o, m_q.size() != DEPTH);
    chk("busy", busy_o, m_inflight || m_q.size() != 0);
    chk("err", err_o, m_err);
  endtask

  task automatic tick(input bit inj);
    commit();
    @(negedge clk);
    cyc++;
    eval();
    core_res_v_i = (cyc == m_res_due) || (inj && !(m_inflight && cyc > m_launch_cyc));
  endtask

  task automatic do_reset();
    in_v_i = 1'b0;
    core_res_v_i = 1'b0;
    #1 nreset = 1'b0;
    #1;
    chk("rst_launch", core_data_v_o, 1'b0);
    chk("rst_data", core_data_o, 128'h0);
    chk("rst_key", core_key_o, 128'h0);
    chk("rst_level", level_o, 3'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rdy", in_rdy_o, 1'b1);
    m_q.delete();
    m_qt.delete();
    m_head = 256'h0;
    m_inflight = 1'b0;
    m_free = 0;
    m_res_due = -1;
    m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cyc += 2;
    nreset = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    in_v_i = 1'b0;
    while ((m_inflight || m_q.size() != 0) && n < 400) begin
      tick(1'b0);
      n++;
    end
    tick(1'b0);
    tick(1'b0);
    chk("drain_idle", busy_o, 1'b0);
  endtask

  initial begin
    logic [255:0] blk [8];
    int s;
    int d;
    bit exp_v;

    do_reset();
    tick(1'b0);

    // AES-128 reference vector: pulse two cycles after the push
    s = cyc;
    in_v_i = 1'b1;
    in_data_i = 128'h00112233445566778899aabbccddeeff;
    in_key_i  = 128'h000102030405060708090a0b0c0d0e0f;
    tick(1'b0);
    in_v_i = 1'b0;
    chk("t1_no_early_launch", core_data_v_o, 1'b0);
    tick(1'b0);
    chk("t1_launch_at_push_plus2", core_data_v_o, 1'b1);
    chk("t1_data_lit", core_data_o, 128'h00112233445566778899aabbccddeeff);
    chk("t1_key_lit", core_key_o, 128'h000102030405060708090a0b0c0d0e0f);
    tick(1'b0);
    chk("t1_single_pulse", core_data_v_o, 1'b0);
    drain();

    // Four back-to-back pushes: launches every 13 cycles, in push order
    s = cyc;
    for (int k = 0; k < 43; k++) begin
      if (k < 4) begin
        chk("t2_rdy", in_rdy_o, 1'b1);
        blk[k] = rnd256();
        in_v_i = 1'b1;
        {in_data_i, in_key_i} = blk[k];
      end else begin
        in_v_i = 1'b0;
      end
      tick(1'b0);
      d = cyc - s - 2;
      exp_v = (d >= 0) && (d % 13 == 0) && (d / 13 < 4);
      chk("t2_launch_spacing", core_data_v_o, exp_v);
      if (exp_v) chk("t2_order", core_data_o, blk[d / 13][255:128]);
    end
    drain();

    // Hold in_v until full; the pop cycle must not accept a push
    s = cyc;
    for (int k = 0; k <= 16; k++) begin
      if (k == 5)  begin chk("t3_full_level", level_o, 3'd4); chk("t3_full_rdy", in_rdy_o, 1'b0); end
      if (k == 14) begin chk("t3_pop_cycle_level", level_o, 3'd4); chk("t3_pop_cycle_rdy", in_rdy_o, 1'b0); end
      if (k == 15) begin chk("t3_after_pop_level", level_o, 3'd3); chk("t3_launch", core_data_v_o, 1'b1); end
      if (k == 16) chk("t3_refill_level", level_o, 3'd4);
      in_v_i = 1'b1;
      {in_data_i, in_key_i} = rnd256();
      tick(1'b0);
    end
    drain();

    // Random traffic with stray core_res_v_i pulses outside RUN
    cnt_push = 0;
    cnt_launch = 0;
    for (int k = 0; k < 400; k++) begin
      in_v_i = ($urandom_range(0, 2) != 0);
      {in_data_i, in_key_i} = rnd256();
      tick($urandom_range(0, 4) == 0);
    end
    drain();
    chk("t4_launch_count", cnt_launch, cnt_push);

    // Reset mid-RUN with two blocks queued
    s = cyc;
    for (int k = 0; k < 5; k++) begin
      in_v_i = (k < 3);
      {in_data_i, in_key_i} = rnd256();
      tick(1'b0);
    end
    chk("t5_queued_before_reset", level_o, 3'd2);
    do_reset();
    for (int k = 0; k < 20; k++) tick(1'b0);
    chk("t5_no_launch_after_reset", busy_o, 1'b0);
    in_v_i = 1'b1;
    {in_data_i, in_key_i} = rnd256();
    tick(1'b0);
    in_v_i = 1'b0;
    tick(1'b0);
    chk("t5_relaunch", core_data_v_o, 1'b1);
    drain();

    // Core never answers
    suppress_core = 1'b1;
    s = cyc;
    for (int k = 0; k <= 40; k++) begin
      in_v_i = (k < 2);
      {in_data_i, in_key_i} = rnd256();
`ifdef AES_FEEDER_WDOG_EN
      if (k == 17) chk("t6_err_clear_before_limit", err_o, 1'b0);
      if (k == 18) chk("t6_err_set", err_o, 1'b1);
      if (k == 19) chk("t6_next_launch", core_data_v_o, 1'b1);
`else
      if (k == 40) begin
        chk("t6_err_stays_0", err_o, 1'b0);
        chk("t6_stuck_busy", busy_o, 1'b1);
        chk("t6_still_queued", level_o, 3'd1);
      end
`endif
      tick(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
